// File: rtl/vga_timing_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Default 640x480@60 timing, sync polarity type, width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int c_DEF_H_ACTIVE = 640;
   localparam int c_DEF_H_FRONT  = 16;
   localparam int c_DEF_H_SYNC   = 96;
   localparam int c_DEF_H_BACK   = 48;
   localparam int c_DEF_V_ACTIVE = 480;
   localparam int c_DEF_V_FRONT  = 10;
   localparam int c_DEF_V_SYNC   = 2;
   localparam int c_DEF_V_BACK   = 33;
   localparam int c_DEF_DIV      = 7;
   localparam int c_DEF_POS_W    = 10;

   typedef enum logic {
      SYNC_ACTIVE_LOW  = 1'b0,
      SYNC_ACTIVE_HIGH = 1'b1
   } sync_pol_e;

   // Bits needed to hold the values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Pixel-tick inputs and sync/blank/position outputs of the generator.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
   parameter int POS_W = 10
);
   logic             pix_en;
   logic             resync;
   logic             h_sync;
   logic             v_sync;
   logic             blank_n;
   logic [POS_W-1:0] pos_x;
   logic [POS_W-1:0] pos_y;
   logic             line_start;
   logic             frame_start;

   modport master (
      input  pix_en, resync,
      output h_sync, v_sync, blank_n, pos_x, pos_y, line_start, frame_start
   );

   modport slave (
      output pix_en, resync,
      input  h_sync, v_sync, blank_n, pos_x, pos_y, line_start, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_axis_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Brief    : One timing axis: position counter, divide sub-counter, decode.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int        ACTIVE   = c_DEF_H_ACTIVE,
   parameter int        FRONT    = c_DEF_H_FRONT,
   parameter int        SYNC     = c_DEF_H_SYNC,
   parameter int        BACK     = c_DEF_H_BACK,
   parameter int        DIV      = c_DEF_DIV,
   parameter sync_pol_e SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int        CW       = 10,
   parameter int        POS_W    = c_DEF_POS_W
) (
   input  logic             clk0,
   input  logic             rst_n,
   input  logic             i_step,
   input  logic             i_restart,
   output logic             o_wrap,
   output logic             o_active_nxt,
   output logic             o_sync_nxt,
   output logic [POS_W-1:0] o_pos_nxt
);

   localparam int              c_TOTAL      = ACTIVE + FRONT + SYNC + BACK;
   localparam int              c_DW         = max2(1, clog2(DIV));
   localparam logic [CW-1:0]   c_LAST       = CW'(c_TOTAL - 1);
   localparam logic [CW-1:0]   c_ACT_END    = CW'(ACTIVE);
   localparam logic [CW-1:0]   c_ACT_LAST   = CW'(ACTIVE - 1);
   localparam logic [CW-1:0]   c_SYNC_FIRST = CW'(ACTIVE + FRONT);
   localparam logic [CW-1:0]   c_SYNC_LAST  = CW'(ACTIVE + FRONT + SYNC - 1);
   localparam logic [c_DW-1:0] c_DIV_LAST   = c_DW'(DIV - 1);
   localparam logic            c_SYNC_ON    = (SYNC_POL == SYNC_ACTIVE_HIGH);

   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [c_DW-1:0]  r_div;
   logic [c_DW-1:0]  w_div_nxt;
   logic [POS_W-1:0] r_pos;
   logic [POS_W-1:0] w_pos_nxt;
   logic             w_wrap;
   logic             w_in_sync;

   assign w_wrap = (r_cnt == c_LAST);

   always_comb begin
      w_cnt_nxt = r_cnt;
      w_div_nxt = r_div;
      w_pos_nxt = r_pos;
      if (i_restart || (i_step && w_wrap)) begin
         w_cnt_nxt = '0;
         w_div_nxt = '0;
         w_pos_nxt = '0;
      end else if (i_step) begin
         w_cnt_nxt = r_cnt + 1'b1;
         // Scaled index only moves while the position being entered is visible.
         if (r_cnt < c_ACT_LAST) begin
            if (r_div == c_DIV_LAST) begin
               w_div_nxt = '0;
               w_pos_nxt = r_pos + 1'b1;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= c_LAST;
         r_div <= '0;
         r_pos <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_div <= w_div_nxt;
         r_pos <= w_pos_nxt;
      end
   end

   assign w_in_sync    = (w_cnt_nxt >= c_SYNC_FIRST) && (w_cnt_nxt <= c_SYNC_LAST);
   assign o_wrap       = w_wrap;
   assign o_active_nxt = (w_cnt_nxt < c_ACT_END);
   assign o_sync_nxt   = w_in_sync ? c_SYNC_ON : ~c_SYNC_ON;
   assign o_pos_nxt    = w_pos_nxt;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA timing generator with scaled pixel coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int        H_ACTIVE   = c_DEF_H_ACTIVE,
   parameter int        H_FRONT    = c_DEF_H_FRONT,
   parameter int        H_SYNC     = c_DEF_H_SYNC,
   parameter int        H_BACK     = c_DEF_H_BACK,
   parameter int        V_ACTIVE   = c_DEF_V_ACTIVE,
   parameter int        V_FRONT    = c_DEF_V_FRONT,
   parameter int        V_SYNC     = c_DEF_V_SYNC,
   parameter int        V_BACK     = c_DEF_V_BACK,
   parameter int        H_DIV      = c_DEF_DIV,
   parameter int        V_DIV      = c_DEF_DIV,
   parameter sync_pol_e H_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter sync_pol_e V_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int        POS_W      = c_DEF_POS_W
) (
   input  logic             clk0,
   input  logic             rst_n,
   vga_timing_gen_if.master vga
);

   localparam int   c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int   c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int   c_CW      = clog2(max2(c_H_TOTAL, c_V_TOTAL));
   localparam logic c_H_IDLE  = (H_SYNC_POL == SYNC_ACTIVE_LOW);
   localparam logic c_V_IDLE  = (V_SYNC_POL == SYNC_ACTIVE_LOW);

   logic             w_tick;
   logic             w_restart;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             w_h_act;
   logic             w_v_act;
   logic             w_active;
   logic             w_h_sync;
   logic             w_v_sync;
   logic [POS_W-1:0] w_x;
   logic [POS_W-1:0] w_y;

   logic             r_h_sync;
   logic             r_v_sync;
   logic             r_blank_n;
   logic [POS_W-1:0] r_pos_x;
   logic [POS_W-1:0] r_pos_y;
   logic             r_line_start;
   logic             r_frame_start;

   assign w_tick    = vga.pix_en;
   assign w_restart = vga.pix_en & vga.resync;

   vga_axis_counter #(
      .ACTIVE   (H_ACTIVE),
      .FRONT    (H_FRONT),
      .SYNC     (H_SYNC),
      .BACK     (H_BACK),
      .DIV      (H_DIV),
      .SYNC_POL (H_SYNC_POL),
      .CW       (c_CW),
      .POS_W    (POS_W)
   ) u_h_axis (
      .clk0         (clk0),
      .rst_n        (rst_n),
      .i_step       (w_tick),
      .i_restart    (w_restart),
      .o_wrap       (w_h_wrap),
      .o_active_nxt (w_h_act),
      .o_sync_nxt   (w_h_sync),
      .o_pos_nxt    (w_x)
   );

   // The vertical axis only moves on the tick that wraps the horizontal one.
   vga_axis_counter #(
      .ACTIVE   (V_ACTIVE),
      .FRONT    (V_FRONT),
      .SYNC     (V_SYNC),
      .BACK     (V_BACK),
      .DIV      (V_DIV),
      .SYNC_POL (V_SYNC_POL),
      .CW       (c_CW),
      .POS_W    (POS_W)
   ) u_v_axis (
      .clk0         (clk0),
      .rst_n        (rst_n),
      .i_step       (w_tick & w_h_wrap),
      .i_restart    (w_restart),
      .o_wrap       (w_v_wrap),
      .o_active_nxt (w_v_act),
      .o_sync_nxt   (w_v_sync),
      .o_pos_nxt    (w_y)
   );

   assign w_active = w_h_act & w_v_act;

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         r_h_sync      <= c_H_IDLE;
         r_v_sync      <= c_V_IDLE;
         r_blank_n     <= 1'b0;
         r_pos_x       <= '0;
         r_pos_y       <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         if (w_tick) begin
            r_h_sync      <= w_h_sync;
            r_v_sync      <= w_v_sync;
            r_blank_n     <= w_active;
            r_pos_x       <= w_active ? w_x : '0;
            r_pos_y       <= w_active ? w_y : '0;
            r_line_start  <= w_restart | w_h_wrap;
            r_frame_start <= w_restart | (w_h_wrap & w_v_wrap);
         end
      end
   end

   assign vga.h_sync      = r_h_sync;
   assign vga.v_sync      = r_v_sync;
   assign vga.blank_n     = r_blank_n;
   assign vga.pos_x       = r_pos_x;
   assign vga.pos_y       = r_pos_y;
   assign vga.line_start  = r_line_start;
   assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed scoreboard bench: default timing plus a tiny opposite-polarity mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct {
      int h_act, h_fp, h_sw, h_bp, v_act, v_fp, v_sw, v_bp, h_div, v_div;
      bit h_pol, v_pol;
   } cfg_t;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       bn;
      logic [9:0] px;
      logic [9:0] py;
      logic       ls;
      logic       fs;
   } out_t;

   logic clk0 = 1'b0;
   logic rst_n_a;
   logic rst_n_b;
   always #5 clk0 = ~clk0;

   vga_timing_gen_if #(.POS_W(10)) if_a ();
   vga_timing_gen_if #(.POS_W(10)) if_b ();

   vga_timing_gen u_dut_a (.clk0(clk0), .rst_n(rst_n_a), .vga(if_a));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_DIV(3), .V_DIV(2),
      .H_SYNC_POL(SYNC_ACTIVE_HIGH), .V_SYNC_POL(SYNC_ACTIVE_HIGH),
      .POS_W(10)
   ) u_dut_b (.clk0(clk0), .rst_n(rst_n_b), .vga(if_b));

   cfg_t cfg [2];
   int   mh [2];
   int   mv [2];
   out_t mexp [2];
   out_t sb_q [$];
   out_t line0 [800];
   int   px_seq [0:7] = '{0, 0, 0, 1, 1, 1, 2, 2};
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic int h_total(input int d);
      return cfg[d].h_act + cfg[d].h_fp + cfg[d].h_sw + cfg[d].h_bp;
   endfunction

   function automatic int v_total(input int d);
      return cfg[d].v_act + cfg[d].v_fp + cfg[d].v_sw + cfg[d].v_bp;
   endfunction

   task automatic model_reset(input int d);
      mh[d]      = h_total(d) - 1;
      mv[d]      = v_total(d) - 1;
      mexp[d]    = '0;
      mexp[d].hs = ~cfg[d].h_pol;
      mexp[d].vs = ~cfg[d].v_pol;
   endtask

   // Reference: positions are tracked directly; outputs derived from the window formulas.
   task automatic model_tick(input int d, input logic pe, input logic rs);
      int   hf, hl, vf, vl;
      out_t e;
      e    = mexp[d];
      e.ls = 1'b0;
      e.fs = 1'b0;
      if (pe) begin
         if (rs) begin
            mh[d] = 0;
            mv[d] = 0;
         end else if (mh[d] == h_total(d) - 1) begin
            mh[d] = 0;
            mv[d] = (mv[d] == v_total(d) - 1) ? 0 : mv[d] + 1;
         end else begin
            mh[d] = mh[d] + 1;
         end
         hf   = cfg[d].h_act + cfg[d].h_fp;
         hl   = hf + cfg[d].h_sw - 1;
         vf   = cfg[d].v_act + cfg[d].v_fp;
         vl   = vf + cfg[d].v_sw - 1;
         e.hs = (mh[d] >= hf && mh[d] <= hl) ? cfg[d].h_pol : ~cfg[d].h_pol;
         e.vs = (mv[d] >= vf && mv[d] <= vl) ? cfg[d].v_pol : ~cfg[d].v_pol;
         e.bn = (mh[d] < cfg[d].h_act) && (mv[d] < cfg[d].v_act);
         e.px = e.bn ? 10'(mh[d] / cfg[d].h_div) : 10'd0;
         e.py = e.bn ? 10'(mv[d] / cfg[d].v_div) : 10'd0;
         e.ls = (mh[d] == 0);
         e.fs = (mh[d] == 0) && (mv[d] == 0);
      end
      mexp[d] = e;
   endtask

   function automatic out_t observe(input int d);
      out_t o;
      if (d == 0) begin
         o.hs = if_a.h_sync;  o.vs = if_a.v_sync;  o.bn = if_a.blank_n;
         o.px = if_a.pos_x;   o.py = if_a.pos_y;
         o.ls = if_a.line_start; o.fs = if_a.frame_start;
      end else begin
         o.hs = if_b.h_sync;  o.vs = if_b.v_sync;  o.bn = if_b.blank_n;
         o.px = if_b.pos_x;   o.py = if_b.pos_y;
         o.ls = if_b.line_start; o.fs = if_b.frame_start;
      end
      return o;
   endfunction

   task automatic sb_compare(input int d, input out_t o, input string tag);
      out_t e;
      e     = sb_q.pop_front();
      n_vec = n_vec + 1;
      assert (o === e) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s dut%0d @%0t: observed hs=%b vs=%b bn=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b bn=%b x=%0d y=%0d ls=%b fs=%b",
                tag, d, $time, o.hs, o.vs, o.bn, o.px, o.py, o.ls, o.fs,
                e.hs, e.vs, e.bn, e.px, e.py, e.ls, e.fs);
      end
   endtask

   task automatic check(input string tag, input integer obs, input integer exp);
      n_vec = n_vec + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic pe, input logic rs);
      if (d == 0) begin
         if_a.pix_en = pe;
         if_a.resync = rs;
      end else begin
         if_b.pix_en = pe;
         if_b.resync = rs;
      end
   endtask

   task automatic step(input int d, input logic pe, input logic rs, output out_t o);
      drive(d, pe, rs);
      model_tick(d, pe, rs);
      sb_q.push_back(mexp[d]);
      @(posedge clk0);
      #1;
      o = observe(d);
      sb_compare(d, o, "tick");
      drive(d, 1'b0, 1'b0);
   endtask

   task automatic check_now(input int d, input string tag);
      sb_q.push_back(mexp[d]);
      sb_compare(d, observe(d), tag);
   endtask

   initial begin
      out_t o;
      logic prev_hs, prev_ls, prev_fs;
      int   fall, rise, line2, xmax, ymax, first_ev, second_ev, wide, n_diff;
      int   hs_cnt, hs_first, vs_lines, vs_line_idx, act_lines;

      cfg[0] = '{h_act:640, h_fp:16, h_sw:96, h_bp:48, v_act:480, v_fp:10, v_sw:2, v_bp:33,
                 h_div:7, v_div:7, h_pol:1'b0, v_pol:1'b0};
      cfg[1] = '{h_act:8, h_fp:1, h_sw:2, h_bp:1, v_act:4, v_fp:1, v_sw:1, v_bp:1,
                 h_div:3, v_div:2, h_pol:1'b1, v_pol:1'b1};
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      model_reset(0);
      model_reset(1);
      repeat (3) @(posedge clk0);
      #1;
      check_now(0, "reset_a");
      check_now(1, "reset_b");
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      @(posedge clk0);
      #1;
      check_now(0, "idle_after_release_a");

      // Default timing, continuous ticks: first nine lines.
      prev_hs = 1'b1; fall = -1; rise = -1; line2 = -1; xmax = 0; ymax = 0;
      for (int t = 0; t <= 6400; t++) begin
         step(0, 1'b1, 1'b0, o);
         if (t < 800) line0[t] = o;
         if (t == 0) begin
            check("a_first_frame_start", o.fs, 1);
            check("a_first_line_start", o.ls, 1);
            check("a_first_blank_n", o.bn, 1);
         end
         if (t == 637) check("a_pos_x_h637", o.px, 91);
         if (t == 639) check("a_pos_x_h639", o.px, 91);
         if (t == 640) check("a_pos_x_h640", o.px, 0);
         if (prev_hs && !o.hs && fall < 0) fall = t;
         if (!prev_hs && o.hs && rise < 0) rise = t;
         prev_hs = o.hs;
         if (o.ls && t > 0 && line2 < 0) line2 = t;
         if (int'(o.px) > xmax) xmax = int'(o.px);
         if (int'(o.py) > ymax) ymax = int'(o.py);
      end
      check("a_hsync_fall_tick", fall, 656);
      check("a_hsync_rise_tick", rise, 752);
      check("a_line_period", line2, 800);
      check("a_pos_x_max", xmax, 91);
      check("a_pos_y_max_line8", ymax, 1);

      // One tick in four: line period stretches to 3200 clocks, strobes stay single.
      first_ev = -1; second_ev = -1; wide = 0; prev_ls = 1'b0;
      for (int i = 0; i < 6400; i++) begin
         step(0, (i % 4) == 0, 1'b0, o);
         if (o.ls) begin
            if (first_ev < 0) first_ev = i;
            else if (second_ev < 0) second_ev = i;
         end
         if (o.ls && prev_ls) wide = wide + 1;
         prev_ls = o.ls;
      end
      check("a_div4_line_period", second_ev - first_ev, 3200);
      check("a_div4_strobe_wide", wide, 0);

      // Resync mid-line: ignored without a tick, then replays the post-reset line.
      for (int t = 0; t < 300; t++) step(0, 1'b1, 1'b0, o);
      step(0, 1'b0, 1'b1, o);
      check("a_resync_no_tick_fs", o.fs, 0);
      step(0, 1'b1, 1'b1, o);
      check("a_resync_fs", o.fs, 1);
      check("a_resync_pos_x", o.px, 0);
      check("a_resync_pos_y", o.py, 0);
      n_diff = (o !== line0[0]) ? 1 : 0;
      for (int t = 1; t < 800; t++) begin
         step(0, 1'b1, 1'b0, o);
         if (o !== line0[t]) n_diff = n_diff + 1;
      end
      check("a_resync_replay_diffs", n_diff, 0);

      // Small mode, active-high syncs: two full frames.
      first_ev = -1; second_ev = -1; hs_cnt = 0; hs_first = -1;
      vs_lines = 0; vs_line_idx = -1; act_lines = 0; ymax = 0;
      for (int t = 0; t <= 168; t++) begin
         step(1, 1'b1, 1'b0, o);
         if (t < 8) check($sformatf("b_pos_x_seq%0d", t), o.px, px_seq[t]);
         if (t < 12 && o.hs) begin
            hs_cnt = hs_cnt + 1;
            if (hs_first < 0) hs_first = t;
         end
         if (o.fs) begin
            if (first_ev < 0) first_ev = t;
            else if (second_ev < 0) second_ev = t;
         end
         if (t < 84 && o.ls) begin
            if (o.vs) begin
               vs_lines    = vs_lines + 1;
               vs_line_idx = t / 12;
            end
            if (o.bn) act_lines = act_lines + 1;
         end
         if (int'(o.py) > ymax) ymax = int'(o.py);
      end
      check("b_first_frame_tick", first_ev, 0);
      check("b_frame_period", second_ev - first_ev, 84);
      check("b_hsync_first_tick", hs_first, 9);
      check("b_hsync_width", hs_cnt, 2);
      check("b_vsync_lines", vs_lines, 1);
      check("b_vsync_line_index", vs_line_idx, 5);
      check("b_active_lines", act_lines, 4);
      check("b_pos_y_max", ymax, 1);

      first_ev = -1; second_ev = -1; wide = 0; prev_fs = 1'b0;
      for (int i = 0; i < 672; i++) begin
         step(1, (i % 4) == 0, 1'b0, o);
         if (o.fs) begin
            if (first_ev < 0) first_ev = i;
            else if (second_ev < 0) second_ev = i;
         end
         if (o.fs && prev_fs) wide = wide + 1;
         prev_fs = o.fs;
      end
      check("b_div4_frame_period", second_ev - first_ev, 336);
      check("b_div4_strobe_wide", wide, 0);

      for (int t = 0; t < 29; t++) step(1, 1'b1, 1'b0, o);
      step(1, 1'b1, 1'b1, o);
      check("b_resync_fs", o.fs, 1);
      check("b_resync_ls", o.ls, 1);

      // Park mid-line inside the picture, then pulse reset between clock edges.
      for (int t = 0; t < 40; t++) step(1, 1'b1, 1'b0, o);
      check("b_premid_pos_x", o.px, 1);
      check("b_premid_pos_y", o.py, 1);
      #2;
      rst_n_b = 1'b0;
      #1;
      model_reset(1);
      check_now(1, "b_async_reset");
      rst_n_b = 1'b1;
      step(1, 1'b1, 1'b0, o);
      check("b_after_reset_fs", o.fs, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator; next generation of our fixed 640x480 sync block. Produces h/v sync with configurable polarity, blanking, integer-downscaled pixel coordinates, and line/frame strobes from a single clock plus a pixel-enable. The coordinate downscaling uses divider sub-counters, with no multipliers. It sits between the pixel clock-enable divider and the framebuffer read / colour output stage.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- H_DIV / V_DIV, 7 / 7, integer downscale factors for pos_x/pos_y (≥1)
- H_SYNC_POL / V_SYNC_POL, 0 / 0, sync active level (0 = active-low)
- POS_W, 10, width of pos_x/pos_y

Ports:
- clk0  in  1  single clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pix_en  in  1  pixel tick; all timing advances only on clk0 edges with pix_en=1
- resync  in  1  restart request; sampled only when pix_en=1
- h_sync  out  1  horizontal sync, level per H_SYNC_POL
- v_sync  out  1  vertical sync, level per V_SYNC_POL
- blank_n  out  1  1 inside the active region
- pos_x  out  POS_W  scaled x, 0 outside active
- pos_y  out  POS_W  scaled y, 0 outside active
- line_start  out  1  one-clk0 pulse on entering h=0
- frame_start  out  1  one-clk0 pulse on entering (h=0, v=0)

## Operation
- Order per axis: active, then front porch, sync, back porch. H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL is defined the same way (525).
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt advances only when h_cnt wraps, and wraps at V_TOTAL-1.
- Horizontal sync window: h_sync is active for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
- Vertical sync window: v_sync is active for v_cnt in the corresponding vertical range. v_sync changes only together with h_cnt→0.
- blank_n = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Scaling uses a sub-counter hd (0..H_DIV-1) that steps with h_cnt while h_cnt is in the active region.
  - When hd wraps, hd→0 and x_div increments.
  - Both reset to 0 at h_cnt=0.
  - The V axis works the same way, stepped per line.
  - pos_x = x_div, so the final partial block keeps the last index (640/7 → pos_x max 91). pos_y max 68.
- resync=1 with pix_en=1: next state is (0,0) with all sub-counters 0. frame_start and line_start pulse. This wins over normal increment.
- pix_en=0: every output holds, except that line_start/frame_start deassert after one clk0.

## Timing
- All outputs are registered and updated on the same edge as the counters. Outputs always describe the position just entered; effective latency from counter to output is 0.
- Reset (rst_n=0, asynchronous):
  - counters = (H_TOTAL-1, V_TOTAL-1), sub-counters 0
  - h_sync = !H_SYNC_POL, v_sync = !V_SYNC_POL
  - blank_n=0, pos_x=pos_y=0, line_start=frame_start=0
- The first pix_en after reset release enters (0,0): blank_n=1, frame_start=1, line_start=1.
- Line period is H_TOTAL pix_en ticks. Frame period is H_TOTAL·V_TOTAL ticks (420000).
- Reset asserted mid-frame immediately forces reset values. No partial-line completion.

## Structure
- Package vga_pkg holds:
  - the default 640x480@60 timing constants
  - a clog2 helper for the counter width CW = clog2(max(H_TOTAL, V_TOTAL))
  - a sync-polarity enum
- One sub-module, vga_axis_counter, is instantiated twice (H and V). Each instance contains:
  - a step input and a wrap output
  - the div sub-counter
  - active and sync-window decode with polarity
- The top level chains the two instances and handles resync and the strobes.

## Test plan
- Reset release with pix_en=1 continuous → first edge: frame_start=1, blank_n=1, pos=(0,0). h_sync falls at tick 656 and rises at tick 752.
- Full frame at defaults → exactly 420000 ticks between frame_start pulses. v_sync is low for lines 490–491 only. 480 lines have blank_n high.
- Scaling check at defaults → pos_x increments every 7 active ticks and reaches 91 at h=637..639. pos_x=0 at h=640. pos_y max 68.
- pix_en pattern 1-of-4 → all outputs hold between ticks. Strobes are exactly one clk0 wide. Period scales by 4×.
- resync at (h=300, v=200) → next tick (0,0), frame_start=1, pos=(0,0). The resumed sequence is identical to the post-reset sequence.
- Small params with opposite polarity:
  - settings: H_ACTIVE=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_ACTIVE=4, V_FRONT/V_SYNC/V_BACK=1/1/1, H_DIV=3, SYNC_POL=1
  - expected: h_sync high at h=9..10, pos_x sequence 0,0,0,1,1,1,2,2, async reset mid-line restores reset values without a clock edge.
